// File: rtl/ovi_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : ovi_seq_pkg
// Brief  : Shared OVI widths, scoreboard entry type and pointer/count helpers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_SCALAROPND_WIDTH
`define OVI_SCALAROPND_WIDTH 64
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 15
`endif
`ifndef OVI_SBID_WIDTH
`define OVI_SBID_WIDTH 5
`endif
`ifndef OVI_FFLAGS_WIDTH
`define OVI_FFLAGS_WIDTH 5
`endif
`ifndef OVI_DATA_WIDTH
`define OVI_DATA_WIDTH 64
`endif

package ovi_seq_pkg;

   localparam int C_DEFAULT_DEPTH   = 8;
   localparam int C_DEFAULT_CREDITS = 4;

   typedef struct packed {
      logic                             valid;
      logic                             done;
      logic [`OVI_SCALAROPND_WIDTH-1:0] dest_reg;
      logic [`OVI_FFLAGS_WIDTH-1:0]     fflags;
      logic                             vxsat;
      logic                             illegal;
   } sb_entry_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return ptr_width(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ovi_credit_ctr.sv
//------------------------------------------------------------------------------
// Module : ovi_credit_ctr
// Brief  : VPU issue credit counter; a return while already full is flagged.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ovi_credit_ctr #(
   parameter int INIT_CREDITS = 4
) (
   input  logic clk,
   input  logic rst_l,
   input  logic i_dec,
   input  logic i_inc,
   output logic o_has_credit,
   output logic o_overflow
);

   localparam int              C_CW   = $clog2(INIT_CREDITS + 1);
   localparam logic [C_CW-1:0] C_INIT = C_CW'(INIT_CREDITS);

   logic [C_CW-1:0] r_credits;
   logic            w_full;
   logic            w_inc_ok;

   always_comb begin
      w_full       = (r_credits == C_INIT);
      w_inc_ok     = i_inc && !w_full;
      o_overflow   = i_inc && w_full;
      o_has_credit = (r_credits != '0);
   end

   // A rejected return does not cancel a same-cycle decrement.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_credits <= C_INIT;
      end else if (w_inc_ok && !i_dec) begin
         r_credits <= r_credits + C_CW'(1);
      end else if (i_dec && !w_inc_ok) begin
         r_credits <= r_credits - C_CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/ovi_issue_sequencer.sv
//------------------------------------------------------------------------------
// Module : ovi_issue_sequencer
// Brief  : Credit-controlled OVI issue with in-order completion retirement.
//          Optional macro OVI_ISSUE_VILL_CHECK_EN retires vill instructions locally.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ovi_issue_sequencer
   import ovi_seq_pkg::*;
#(
   parameter int DEPTH        = C_DEFAULT_DEPTH,
   parameter int INIT_CREDITS = C_DEFAULT_CREDITS
) (
   input  logic                             clk,
   input  logic                             rst_l,
   input  logic                             core_issue_valid,
   output logic                             core_issue_ready,
   input  logic [`OVI_INSTR_WIDTH-1:0]      core_issue_instr,
   input  logic [`OVI_SCALAROPND_WIDTH-1:0] core_issue_scalar_opnd,
   input  logic                             csr_vill,
   input  logic [`OVI_SEW_WIDTH-1:0]        csr_vsew,
   input  logic [1:0]                       csr_vlmul,
   input  logic [2:0]                       csr_frm,
   input  logic [1:0]                       csr_vxrm,
   input  logic [`OVI_VL_WIDTH-1:0]         csr_vl,
   input  logic [13:0]                      csr_vstart,
   output logic                             vpu_issue_valid,
   output logic [`OVI_INSTR_WIDTH-1:0]      vpu_issue_instr,
   output logic [`OVI_SCALAROPND_WIDTH-1:0] vpu_issue_scalar_opnd,
   output logic [`OVI_SBID_WIDTH-1:0]       vpu_issue_sb_id,
   output logic                             vpu_issue_vill,
   output logic [`OVI_SEW_WIDTH-1:0]        vpu_issue_vsew,
   output logic [1:0]                       vpu_issue_vlmul,
   output logic [2:0]                       vpu_issue_frm,
   output logic [1:0]                       vpu_issue_vxrm,
   output logic [`OVI_VL_WIDTH-1:0]         vpu_issue_vl,
   output logic [13:0]                      vpu_issue_vstart,
   input  logic                             vpu_issue_credit,
   input  logic                             vpu_cmpl_valid,
   input  logic [`OVI_SBID_WIDTH-1:0]       vpu_cmpl_sb_id,
   input  logic [`OVI_SCALAROPND_WIDTH-1:0] vpu_cmpl_dest_reg,
   input  logic [`OVI_FFLAGS_WIDTH-1:0]     vpu_cmpl_fflags,
   input  logic                             vpu_cmpl_vxsat,
   input  logic                             vpu_cmpl_illegal,
   output logic                             core_cmpl_valid,
   output logic [`OVI_DATA_WIDTH-1:0]       core_cmpl_data,
   output logic [`OVI_FFLAGS_WIDTH-1:0]     core_cmpl_fflags,
   output logic                             core_cmpl_vxsat,
   output logic                             core_cmpl_illegal,
   output logic [$clog2(DEPTH):0]           outstanding,
   output logic                             proto_err
);

   localparam int                 C_PTR_W     = ptr_width(DEPTH);
   localparam int                 C_CNT_W     = cnt_width(DEPTH);
   localparam int                 C_DW        = `OVI_DATA_WIDTH;
   localparam int                 C_SW        = `OVI_SCALAROPND_WIDTH;
   localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);

   sb_entry_t          r_sb [DEPTH];
   logic [C_PTR_W-1:0] r_head;
   logic [C_PTR_W-1:0] r_tail;
   logic [C_CNT_W-1:0] r_count;
   logic               r_proto_err;

   logic               w_has_credit;
   logic               w_credit_ovf;
   logic               w_accept;
   logic               w_vill_alloc;
   logic               w_issue;
   logic [C_PTR_W-1:0] w_cmpl_idx;
   sb_entry_t          w_cmpl_entry;
   sb_entry_t          w_head_entry;
   logic               w_cmpl_hit;
   logic               w_cmpl_err;
   logic               w_retire;
   logic [C_DW-1:0]    w_ret_data;

   ovi_credit_ctr #(
      .INIT_CREDITS (INIT_CREDITS)
   ) u_credit_ctr (
      .clk          (clk),
      .rst_l        (rst_l),
      .i_dec        (w_issue),
      .i_inc        (vpu_issue_credit),
      .o_has_credit (w_has_credit),
      .o_overflow   (w_credit_ovf)
   );

   always_comb begin
      core_issue_ready = (r_count < C_DEPTH_CNT) && w_has_credit;
      w_accept         = core_issue_valid && core_issue_ready;
`ifdef OVI_ISSUE_VILL_CHECK_EN
      w_vill_alloc     = w_accept && csr_vill;
`else
      w_vill_alloc     = 1'b0;
`endif
      w_issue          = w_accept && !w_vill_alloc;
      w_cmpl_idx       = vpu_cmpl_sb_id[C_PTR_W-1:0];
      w_cmpl_entry     = r_sb[w_cmpl_idx];
      // Out-of-range ids, idle slots and repeat completions all count as errors.
      w_cmpl_hit       = vpu_cmpl_valid && (32'(vpu_cmpl_sb_id) < DEPTH) &&
                         w_cmpl_entry.valid && !w_cmpl_entry.done;
      w_cmpl_err       = vpu_cmpl_valid && !w_cmpl_hit;
      w_head_entry     = r_sb[r_head];
      w_retire         = w_head_entry.valid && w_head_entry.done;
   end

   if (C_DW == C_SW) begin : g_data_same
      assign w_ret_data = w_head_entry.dest_reg;
   end else if (C_DW > C_SW) begin : g_data_zext
      assign w_ret_data = {{(C_DW - C_SW){1'b0}}, w_head_entry.dest_reg};
   end else begin : g_data_trunc
      assign w_ret_data = w_head_entry.dest_reg[C_DW-1:0];
   end

   // Accept, completion and retire never target the same slot in one cycle.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_sb[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_sb[r_tail] <= '{valid: 1'b1, done: w_vill_alloc, dest_reg: '0,
                              fflags: '0, vxsat: 1'b0, illegal: w_vill_alloc};
         end
         if (w_cmpl_hit) begin
            r_sb[w_cmpl_idx].done     <= 1'b1;
            r_sb[w_cmpl_idx].dest_reg <= vpu_cmpl_dest_reg;
            r_sb[w_cmpl_idx].fflags   <= vpu_cmpl_fflags;
            r_sb[w_cmpl_idx].vxsat    <= vpu_cmpl_vxsat;
            r_sb[w_cmpl_idx].illegal  <= vpu_cmpl_illegal;
         end
         if (w_retire) begin
            r_sb[r_head].valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tail <= r_tail + C_PTR_W'(1);
         end
         if (w_retire) begin
            r_head <= r_head + C_PTR_W'(1);
         end
         case ({w_accept, w_retire})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_credit_ovf || w_cmpl_err) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         vpu_issue_valid       <= 1'b0;
         vpu_issue_instr       <= '0;
         vpu_issue_scalar_opnd <= '0;
         vpu_issue_sb_id       <= '0;
         vpu_issue_vill        <= 1'b0;
         vpu_issue_vsew        <= '0;
         vpu_issue_vlmul       <= '0;
         vpu_issue_frm         <= '0;
         vpu_issue_vxrm        <= '0;
         vpu_issue_vl          <= '0;
         vpu_issue_vstart      <= '0;
      end else begin
         vpu_issue_valid <= w_issue;
         if (w_issue) begin
            vpu_issue_instr       <= core_issue_instr;
            vpu_issue_scalar_opnd <= core_issue_scalar_opnd;
            vpu_issue_sb_id       <= `OVI_SBID_WIDTH'(r_tail);
            vpu_issue_vill        <= csr_vill;
            vpu_issue_vsew        <= csr_vsew;
            vpu_issue_vlmul       <= csr_vlmul;
            vpu_issue_frm         <= csr_frm;
            vpu_issue_vxrm        <= csr_vxrm;
            vpu_issue_vl          <= csr_vl;
            vpu_issue_vstart      <= csr_vstart;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         core_cmpl_valid   <= 1'b0;
         core_cmpl_data    <= '0;
         core_cmpl_fflags  <= '0;
         core_cmpl_vxsat   <= 1'b0;
         core_cmpl_illegal <= 1'b0;
      end else begin
         core_cmpl_valid <= w_retire;
         if (w_retire) begin
            core_cmpl_data    <= w_ret_data;
            core_cmpl_fflags  <= w_head_entry.fflags;
            core_cmpl_vxsat   <= w_head_entry.vxsat;
            core_cmpl_illegal <= w_head_entry.illegal;
         end
      end
   end

   assign outstanding = r_count;
   assign proto_err   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_ovi_issue_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_ovi_issue_sequencer
// Brief  : Random and directed stimulus checked against a queue-based model.
//          Honours OVI_ISSUE_VILL_CHECK_EN when defined.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_SCALAROPND_WIDTH
`define OVI_SCALAROPND_WIDTH 64
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 15
`endif
`ifndef OVI_SBID_WIDTH
`define OVI_SBID_WIDTH 5
`endif
`ifndef OVI_FFLAGS_WIDTH
`define OVI_FFLAGS_WIDTH 5
`endif
`ifndef OVI_DATA_WIDTH
`define OVI_DATA_WIDTH 64
`endif

module tb_ovi_issue_sequencer;

   localparam int DEPTH        = 8;
   localparam int INIT_CREDITS = 4;
   localparam int IW  = `OVI_INSTR_WIDTH;
   localparam int SW  = `OVI_SCALAROPND_WIDTH;
   localparam int EW  = `OVI_SEW_WIDTH;
   localparam int LW  = `OVI_VL_WIDTH;
   localparam int BW  = `OVI_SBID_WIDTH;
   localparam int FW  = `OVI_FFLAGS_WIDTH;
   localparam int DW  = `OVI_DATA_WIDTH;
   localparam int OW  = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_l;
   logic          civ;
   logic          core_issue_ready;
   logic [IW-1:0] instr;
   logic [SW-1:0] opnd;
   logic          vill;
   logic [EW-1:0] vsew;
   logic [1:0]    vlmul;
   logic [2:0]    frm;
   logic [1:0]    vxrm;
   logic [LW-1:0] vl;
   logic [13:0]   vstart;
   logic          vpu_issue_valid;
   logic [IW-1:0] vpu_issue_instr;
   logic [SW-1:0] vpu_issue_scalar_opnd;
   logic [BW-1:0] vpu_issue_sb_id;
   logic          vpu_issue_vill;
   logic [EW-1:0] vpu_issue_vsew;
   logic [1:0]    vpu_issue_vlmul;
   logic [2:0]    vpu_issue_frm;
   logic [1:0]    vpu_issue_vxrm;
   logic [LW-1:0] vpu_issue_vl;
   logic [13:0]   vpu_issue_vstart;
   logic          credit;
   logic          cv;
   logic [BW-1:0] csb;
   logic [SW-1:0] cdest;
   logic [FW-1:0] cff;
   logic          cvx;
   logic          cill;
   logic          core_cmpl_valid;
   logic [DW-1:0] core_cmpl_data;
   logic [FW-1:0] core_cmpl_fflags;
   logic          core_cmpl_vxsat;
   logic          core_cmpl_illegal;
   logic [OW-1:0] outstanding;
   logic          proto_err;

   ovi_issue_sequencer #(
      .DEPTH        (DEPTH),
      .INIT_CREDITS (INIT_CREDITS)
   ) dut (
      .clk                    (clk),
      .rst_l                  (rst_l),
      .core_issue_valid       (civ),
      .core_issue_ready       (core_issue_ready),
      .core_issue_instr       (instr),
      .core_issue_scalar_opnd (opnd),
      .csr_vill               (vill),
      .csr_vsew               (vsew),
      .csr_vlmul              (vlmul),
      .csr_frm                (frm),
      .csr_vxrm               (vxrm),
      .csr_vl                 (vl),
      .csr_vstart             (vstart),
      .vpu_issue_valid        (vpu_issue_valid),
      .vpu_issue_instr        (vpu_issue_instr),
      .vpu_issue_scalar_opnd  (vpu_issue_scalar_opnd),
      .vpu_issue_sb_id        (vpu_issue_sb_id),
      .vpu_issue_vill         (vpu_issue_vill),
      .vpu_issue_vsew         (vpu_issue_vsew),
      .vpu_issue_vlmul        (vpu_issue_vlmul),
      .vpu_issue_frm          (vpu_issue_frm),
      .vpu_issue_vxrm         (vpu_issue_vxrm),
      .vpu_issue_vl           (vpu_issue_vl),
      .vpu_issue_vstart       (vpu_issue_vstart),
      .vpu_issue_credit       (credit),
      .vpu_cmpl_valid         (cv),
      .vpu_cmpl_sb_id         (csb),
      .vpu_cmpl_dest_reg      (cdest),
      .vpu_cmpl_fflags        (cff),
      .vpu_cmpl_vxsat         (cvx),
      .vpu_cmpl_illegal       (cill),
      .core_cmpl_valid        (core_cmpl_valid),
      .core_cmpl_data         (core_cmpl_data),
      .core_cmpl_fflags       (core_cmpl_fflags),
      .core_cmpl_vxsat        (core_cmpl_vxsat),
      .core_cmpl_illegal      (core_cmpl_illegal),
      .outstanding            (outstanding),
      .proto_err              (proto_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: in-flight instructions kept oldest-first.
   typedef struct {
      int            id;
      bit            done;
      logic [SW-1:0] data;
      logic [FW-1:0] fflags;
      bit            vxsat;
      bit            illegal;
   } rec_t;

   rec_t          q[$];
   int            m_credits;
   bit            m_proto;
   int            m_tail;
   bit            e_iv;
   bit            e_cv;
   int            e_sbid;
   logic [IW-1:0] e_instr;
   logic [SW-1:0] e_opnd;
   logic          e_vill;
   logic [EW-1:0] e_vsew;
   logic [1:0]    e_vlmul;
   logic [2:0]    e_frm;
   logic [1:0]    e_vxrm;
   logic [LW-1:0] e_vl;
   logic [13:0]   e_vstart;
   logic [SW-1:0] e_data;
   logic [FW-1:0] e_ff;
   bit            e_vx;
   bit            e_ill;

   function automatic bit m_ready();
      return (q.size() < DEPTH) && (m_credits > 0);
   endfunction

   task automatic model_reset();
      q.delete();
      m_credits = INIT_CREDITS;
      m_proto   = 1'b0;
      m_tail    = 0;
      e_iv      = 1'b0;
      e_cv      = 1'b0;
   endtask

   task automatic model_step();
      bit acc;
      bit va;
      bit ret;
      int hit;
      acc = civ && m_ready();
      va  = 1'b0;
`ifdef OVI_ISSUE_VILL_CHECK_EN
      va  = acc && vill;
`endif
      ret = (q.size() > 0) && q[0].done;
      if (cv) begin
         hit = -1;
         foreach (q[k]) if (q[k].id == int'(csb) && !q[k].done) hit = k;
         if (hit >= 0) begin
            q[hit].done    = 1'b1;
            q[hit].data    = cdest;
            q[hit].fflags  = cff;
            q[hit].vxsat   = cvx;
            q[hit].illegal = cill;
         end else begin
            m_proto = 1'b1;
         end
      end
      e_cv = ret;
      if (ret) begin
         e_data = q[0].data;
         e_ff   = q[0].fflags;
         e_vx   = q[0].vxsat;
         e_ill  = q[0].illegal;
         void'(q.pop_front());
      end
      if (credit) begin
         if (m_credits == INIT_CREDITS) m_proto = 1'b1;
         else m_credits++;
      end
      if (acc && !va) m_credits--;
      e_iv = acc && !va;
      if (e_iv) begin
         e_sbid = m_tail;  e_instr = instr;  e_opnd = opnd;  e_vill = vill;
         e_vsew = vsew;    e_vlmul = vlmul;  e_frm = frm;    e_vxrm = vxrm;
         e_vl = vl;        e_vstart = vstart;
      end
      if (acc) begin
         q.push_back('{id: m_tail, done: va, data: '0, fflags: '0, vxsat: 1'b0, illegal: va});
         m_tail = (m_tail + 1) % DEPTH;
      end
   endtask

   task automatic check_all();
      check_eq("ready", core_issue_ready, m_ready());
      check_eq("issue_valid", vpu_issue_valid, e_iv);
      if (e_iv) begin
         check_eq("issue_sb_id", vpu_issue_sb_id, e_sbid);
         check_eq("issue_instr", vpu_issue_instr, e_instr);
         check_eq("issue_opnd", vpu_issue_scalar_opnd, e_opnd);
         check_eq("issue_vill", vpu_issue_vill, e_vill);
         check_eq("issue_csr", {vpu_issue_vsew, vpu_issue_vlmul, vpu_issue_frm, vpu_issue_vxrm},
                  {e_vsew, e_vlmul, e_frm, e_vxrm});
         check_eq("issue_vl_vstart", {vpu_issue_vl, vpu_issue_vstart}, {e_vl, e_vstart});
      end
      check_eq("cmpl_valid", core_cmpl_valid, e_cv);
      if (e_cv) begin
         check_eq("cmpl_data", core_cmpl_data, e_data);
         check_eq("cmpl_flags", {core_cmpl_fflags, core_cmpl_vxsat, core_cmpl_illegal},
                  {e_ff, e_vx, e_ill});
      end
      check_eq("outstanding", outstanding, q.size());
      check_eq("proto_err", proto_err, m_proto);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_issue_valid", vpu_issue_valid, 0);
      check_eq("rst_issue_payload", {vpu_issue_instr, vpu_issue_sb_id, vpu_issue_vill}, 0);
      check_eq("rst_issue_opnd", vpu_issue_scalar_opnd, 0);
      check_eq("rst_issue_csr", {vpu_issue_vsew, vpu_issue_vlmul, vpu_issue_frm, vpu_issue_vxrm,
                                 vpu_issue_vl, vpu_issue_vstart}, 0);
      check_eq("rst_cmpl", {core_cmpl_valid, core_cmpl_fflags, core_cmpl_vxsat, core_cmpl_illegal}, 0);
      check_eq("rst_cmpl_data", core_cmpl_data, 0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_proto_err", proto_err, 0);
      check_eq("rst_ready", core_issue_ready, 1);
   endtask

   task automatic idle();
      civ = 1'b0;  credit = 1'b0;  cv = 1'b0;
   endtask

   task automatic rand_payload();
      instr  = IW'($urandom);
      opnd   = {32'($urandom), 32'($urandom)};
      vill   = ($urandom_range(0, 9) == 0);
      vsew   = EW'($urandom);
      vlmul  = 2'($urandom);
      frm    = 3'($urandom);
      vxrm   = 2'($urandom);
      vl     = LW'($urandom);
      vstart = 14'($urandom);
   endtask

   task automatic set_cmpl(input int id, input logic [SW-1:0] dest);
      cv    = 1'b1;
      csb   = BW'(id);
      cdest = dest;
      cff   = FW'($urandom);
      cvx   = 1'($urandom);
      cill  = 1'($urandom);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   // Assert reset asynchronously mid-cycle; returns on a negedge after release.
   task automatic do_reset();
      idle();
      #1 rst_l = 1'b0;
      model_reset();
      #2 check_reset_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b1;
   endtask

   // Complete every outstanding instruction in random order, then let all retire.
   task automatic drain();
      int cand[$];
      for (int n = 0; n < 200 && q.size() > 0; n++) begin
         idle();
         cand.delete();
         foreach (q[k]) if (!q[k].done) cand.push_back(q[k].id);
         if (cand.size() > 0 && $urandom_range(0, 1) == 1)
            set_cmpl(cand[$urandom_range(0, cand.size() - 1)], {32'($urandom), 32'($urandom)});
         if (m_credits < INIT_CREDITS && $urandom_range(0, 1) == 1) credit = 1'b1;
         step();
      end
      idle();
      step();
      check_eq("drain_empty", outstanding, 0);
   endtask

   initial begin
      idle();
      rand_payload();
      vill  = 1'b0;
      csb   = '0;
      cdest = '0;
      cff   = '0;
      cvx   = 1'b0;
      cill  = 1'b0;
      rst_l = 1'b0;
      model_reset();
      #12 check_reset_outputs();
      @(negedge clk);
      rst_l = 1'b1;

      // Back-to-back accepts until credits run out, then one credit returns.
      for (int i = 0; i < 5; i++) begin
         civ = 1'b1;
         rand_payload();
         vill = 1'b0;
         step();
      end
      idle();
      step();
      check_eq("ready_no_credit", core_issue_ready, 0);
      credit = 1'b1;
      step();
      idle();
      check_eq("ready_after_credit", core_issue_ready, 1);
      step();

      // Out-of-order completions 2,0,1 retire as 0,1,2.
      set_cmpl(2, 64'hA2);  step();
      set_cmpl(0, 64'hA0);  step();
      set_cmpl(1, 64'hA1);  step();
      idle();
      for (int i = 0; i < 4; i++) step();

      // Fill the scoreboard with credits returned immediately.
      for (int i = 0; i < 20; i++) begin
         civ = 1'b1;
         rand_payload();
         vill   = 1'b0;
         credit = (m_credits < INIT_CREDITS);
         step();
      end
      check_eq("full_outstanding", outstanding, DEPTH);
      check_eq("full_ready", core_issue_ready, 0);
      set_cmpl(q[0].id, 64'h11);  step();
      set_cmpl(q[1].id, 64'h22);  step();
      cv = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_payload();
         vill   = 1'b0;
         credit = (m_credits < INIT_CREDITS);
         step();
      end
      drain();

      // vill instruction sandwiched between two normal ones.
      for (int i = 0; i < 3; i++) begin
         civ = 1'b1;
         rand_payload();
         vill   = (i == 1);
         credit = (m_credits < INIT_CREDITS);
         step();
      end
      drain();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         int cand[$];
         idle();
         civ = ($urandom_range(0, 9) < 7);
         rand_payload();
         if (m_credits < INIT_CREDITS && $urandom_range(0, 9) < 5) credit = 1'b1;
         foreach (q[k]) if (!q[k].done) cand.push_back(q[k].id);
         if (cand.size() > 0 && $urandom_range(0, 9) < 4)
            set_cmpl(cand[$urandom_range(0, cand.size() - 1)], {32'($urandom), 32'($urandom)});
         step();
      end
      drain();

      // Completion to an unallocated id is a protocol error.
      do_reset();
      set_cmpl(5, 64'h55);
      step();
      idle();
      for (int i = 0; i < 3; i++) step();
      check_eq("proto_sticky_cmpl", proto_err, 1);

      // Credit while already at the initial count is a protocol error.
      do_reset();
      credit = 1'b1;
      step();
      idle();
      step();
      check_eq("proto_sticky_credit", proto_err, 1);

      // Reset with three in flight discards them; a stale completion is an error.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         civ = 1'b1;
         rand_payload();
         vill = 1'b0;
         step();
      end
      do_reset();
      set_cmpl(1, 64'h77);
      step();
      idle();
      step();
      check_eq("proto_stale_id", proto_err, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
